// File: rtl/store_sequencer.sv
// store_sequencer
//   Front-end control stage for the 4-slot byte latch bank. It synchronizes and
//   debounces the raw store/clear buttons, snapshots the switch byte, steps the
//   slot pointer, and emits a one-cycle store strobe. data_out and sel are held
//   stable around the strobe.
//
// Ports
//   clk         in   100 MHz system clock
//   rst_n       in   asynchronous active-low reset
//   btn_store   in   raw store button (asynchronous, bouncy)
//   btn_clear   in   raw clear button (asynchronous, bouncy)
//   sw[7:0]     in   raw switch byte (asynchronous)
//   data_out    out  registered switch snapshot for the latch bank
//   sel         out  target slot for the latch bank
//   store       out  one-cycle write strobe
//   slot_valid  out  bit i set once slot i is written since the last clear/reset
//   full        out  all four slots valid
//   overflow    out  one-cycle pulse when a press is rejected on a full bank (WRAP=0)
module store_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          WRAP            = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_store,
    input  logic       btn_clear,
    input  logic [7:0] sw,
    output logic [7:0] data_out,
    output logic [1:0] sel,
    output logic       store,
    output logic [3:0] slot_valid,
    output logic       full,
    output logic       overflow
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StStrobe,
        StRelease,
        StWaitRel
    } state_e;

    // Synchronizers
    logic [SYNC_STAGES-1:0]      store_sync_q, store_sync_d;
    logic [SYNC_STAGES-1:0]      clear_sync_q, clear_sync_d;
    logic [SYNC_STAGES-1:0][7:0] sw_sync_q, sw_sync_d;

    // Debouncers: index 0 = store, index 1 = clear
    logic [1:0]      btn_synced;
    logic [1:0]      deb_q, deb_d;
    logic [1:0]      deb_prev_q;
    logic [CntW-1:0] cnt_q [2];
    logic [CntW-1:0] cnt_d [2];
    logic            store_rise, clear_rise;

    // Sequencer
    state_e     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] valid_q, valid_d;
    logic       full_q, full_d;
    logic       overflow_q, overflow_d;
    logic       pend_q, pend_d;
    logic       do_clear;

    always_comb begin
        store_sync_d = {store_sync_q[SYNC_STAGES-2:0], btn_store};
        clear_sync_d = {clear_sync_q[SYNC_STAGES-2:0], btn_clear};
        sw_sync_d    = {sw_sync_q[SYNC_STAGES-2:0], sw};
        btn_synced   = {clear_sync_q[SYNC_STAGES-1], store_sync_q[SYNC_STAGES-1]};
    end

    // Counter runs only while the synced level disagrees with the debounced one,
    // so any disagreement shorter than DEBOUNCE_CYCLES is discarded.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (btn_synced[i] != deb_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    assign store_rise = deb_q[0] & ~deb_prev_q[0];
    assign clear_rise = deb_q[1] & ~deb_prev_q[1];

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        valid_d    = valid_q;
        pend_d     = pend_q;
        overflow_d = 1'b0;
        do_clear   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (clear_rise) begin
                    // Clear wins over a simultaneous store press.
                    do_clear = 1'b1;
                    if (store_rise) state_d = StWaitRel;
                end else if (store_rise) begin
                    if (!full_q || WRAP) begin
                        state_d = StCapture;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = StWaitRel;
                    end
                end
            end
            StCapture: begin
                data_d  = sw_sync_q[SYNC_STAGES-1];
                sel_d   = ptr_q;
                state_d = StStrobe;
                if (clear_rise) pend_d = 1'b1;
            end
            StStrobe: begin
                state_d = StRelease;
                if (clear_rise) pend_d = 1'b1;
            end
            StRelease: begin
                valid_d[sel_q] = 1'b1;
                ptr_d          = ptr_q + 2'd1;
                state_d        = StWaitRel;
                if (clear_rise) pend_d = 1'b1;
            end
            StWaitRel: begin
                // A clear deferred during the write lands here, after the slot bit was set.
                if (pend_q || clear_rise) begin
                    do_clear = 1'b1;
                    pend_d   = 1'b0;
                end
                if (!deb_q[0]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (do_clear) begin
            valid_d = '0;
            ptr_d   = '0;
        end
        full_d = &valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_sync_q <= '0;
            clear_sync_q <= '0;
            sw_sync_q    <= '0;
            deb_q        <= '0;
            deb_prev_q   <= '0;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
            state_q      <= StIdle;
            data_q       <= '0;
            sel_q        <= '0;
            ptr_q        <= '0;
            valid_q      <= '0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            store_sync_q <= store_sync_d;
            clear_sync_q <= clear_sync_d;
            sw_sync_q    <= sw_sync_d;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_q;
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
            state_q      <= state_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            valid_q      <= valid_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
            pend_q       <= pend_d;
        end
    end

    // Decoded straight from the state register so reset drops it immediately.
    assign store      = (state_q == StStrobe);
    assign data_out   = data_q;
    assign sel        = sel_q;
    assign slot_valid = valid_q;
    assign full       = full_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Testbench for store_sequencer: one WRAP=0 and one WRAP=1 instance share the
// same stimulus; each is checked against its own slot/pointer model.
module tb_store_sequencer;

    logic       clk;
    logic       rst_n;
    logic       btn_store;
    logic       btn_clear;
    logic [7:0] sw;

    logic [7:0] data_out   [2];
    logic [1:0] sel        [2];
    logic       store      [2];
    logic [3:0] slot_valid [2];
    logic       full       [2];
    logic       overflow   [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which slots hold data and where the next write goes.
    logic [3:0] m_valid [2];
    int         m_ptr   [2];
    bit         m_wrap  [2];

    store_sequencer #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .WRAP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_store(btn_store), .btn_clear(btn_clear), .sw(sw),
        .data_out(data_out[0]), .sel(sel[0]), .store(store[0]), .slot_valid(slot_valid[0]),
        .full(full[0]), .overflow(overflow[0])
    );

    store_sequencer #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .WRAP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_store(btn_store), .btn_clear(btn_clear), .sw(sw),
        .data_out(data_out[1]), .sel(sel[1]), .store(store[1]), .slot_valid(slot_valid[1]),
        .full(full[1]), .overflow(overflow[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 4'h0;
            m_ptr[k]   = 0;
        end
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s.valid%0d", tag, k), 32'(slot_valid[k]), 32'(m_valid[k]));
            check($sformatf("%s.full%0d", tag, k), 32'(full[k]), 32'(m_valid[k] == 4'hf));
        end
    endtask

    // clr_mode: 0 none, 1 clear rises during STROBE, 2 clear rises with the store press.
    task automatic press(input string tag, input logic [7:0] d, input bit bounce,
                         input int clr_mode);
        int         st_cnt [2];
        int         st_cyc [2];
        int         ov_cnt [2];
        int         ov_cyc [2];
        logic [7:0] st_data [2];
        logic [1:0] st_sel [2];
        logic [7:0] d_after [2];
        bit         exp_wr [2];
        bit         exp_ov [2];
        logic [1:0] exp_sel [2];

        for (int k = 0; k < 2; k++) begin
            st_cnt[k] = 0; st_cyc[k] = 0; ov_cnt[k] = 0; ov_cyc[k] = 0;
            st_data[k] = '0; st_sel[k] = '0; d_after[k] = '0;
            exp_sel[k] = 2'(m_ptr[k]);
            exp_wr[k]  = (clr_mode != 2) && ((m_valid[k] != 4'hf) || m_wrap[k]);
            exp_ov[k]  = (clr_mode != 2) && !exp_wr[k];
        end

        sw = d;
        if (bounce) begin
            // Each bounce is shorter than the debounce window, so none may get through.
            repeat (3) begin
                btn_store = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                btn_store = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        btn_store = 1'b1;
        if (clr_mode == 2) btn_clear = 1'b1;

        for (int c = 1; c <= 12; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (store[k] === 1'b1) begin
                    st_cnt[k]++; st_cyc[k] = c; st_data[k] = data_out[k]; st_sel[k] = sel[k];
                end
                if (overflow[k] === 1'b1) begin
                    ov_cnt[k]++; ov_cyc[k] = c;
                end
                if (c == 9) d_after[k] = data_out[k];
            end
            if (clr_mode == 1 && c == 2) btn_clear = 1'b1;
        end
        btn_store = 1'b0;
        btn_clear = 1'b0;
        repeat (10) tick();

        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s.stores%0d", tag, k), 32'(st_cnt[k]), 32'(exp_wr[k]));
            check($sformatf("%s.ovf%0d", tag, k), 32'(ov_cnt[k]), 32'(exp_ov[k]));
            if (exp_wr[k]) begin
                // Raw edge + 2 sync + 4 debounce = rise cycle, store two cycles later.
                check($sformatf("%s.stcyc%0d", tag, k), 32'(st_cyc[k]), 32'd8);
                check($sformatf("%s.sel%0d", tag, k), 32'(st_sel[k]), 32'(exp_sel[k]));
                check($sformatf("%s.data%0d", tag, k), 32'(st_data[k]), 32'(d));
                check($sformatf("%s.hold%0d", tag, k), 32'(d_after[k]), 32'(d));
                m_valid[k] = m_valid[k] | (4'b0001 << m_ptr[k]);
                m_ptr[k]   = (m_ptr[k] + 1) % 4;
            end
            if (exp_ov[k]) check($sformatf("%s.ovcyc%0d", tag, k), 32'(ov_cyc[k]), 32'd7);
            if (clr_mode != 0) begin
                m_valid[k] = 4'h0;
                m_ptr[k]   = 0;
            end
        end
        check_state(tag);
    endtask

    task automatic clear_only(input string tag);
        btn_clear = 1'b1;
        repeat (10) tick();
        btn_clear = 1'b0;
        repeat (10) tick();
        model_reset();
        check_state(tag);
    endtask

    initial begin
        m_wrap[0] = 1'b0;
        m_wrap[1] = 1'b1;
        model_reset();
        rst_n     = 1'b0;
        btn_store = 1'b0;
        btn_clear = 1'b0;
        sw        = 8'h00;
        repeat (3) tick();

        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst.data%0d", k), 32'(data_out[k]), 32'h0);
            check($sformatf("rst.sel%0d", k), 32'(sel[k]), 32'h0);
            check($sformatf("rst.store%0d", k), 32'(store[k]), 32'h0);
            check($sformatf("rst.ovf%0d", k), 32'(overflow[k]), 32'h0);
        end
        check_state("rst");
        rst_n = 1'b1;
        repeat (2) tick();

        // Reset asserted while the strobe is high.
        sw        = 8'h3c;
        btn_store = 1'b1;
        repeat (8) tick();
        for (int k = 0; k < 2; k++) check($sformatf("midrst.pre%0d", k), 32'(store[k]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("midrst.drop%0d", k), 32'(store[k]), 32'h0);
        btn_store = 1'b0;
        repeat (3) tick();
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("midrst.data%0d", k), 32'(data_out[k]), 32'h0);
            check($sformatf("midrst.sel%0d", k), 32'(sel[k]), 32'h0);
        end
        check_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        press("after_rst", 8'h5a, 1'b0, 0);

        // Clean press of A5 from an empty bank.
        clear_only("clr_a");
        press("a5", 8'ha5, 1'b0, 0);

        // Bouncy press: one write only.
        press("bounce", 8'($urandom), 1'b1, 0);

        // Five presses: WRAP=0 overflows on the fifth, WRAP=1 rewrites slot 0.
        clear_only("clr_b");
        for (int i = 1; i <= 5; i++) press($sformatf("five%0d", i), 8'(i), 1'b0, 0);

        // Clear during the strobe of slot 2, then the next press targets slot 0.
        clear_only("clr_c");
        press("s0", 8'($urandom), 1'b0, 0);
        press("s1", 8'($urandom), 1'b0, 0);
        press("s2_clr", 8'($urandom), 1'b0, 1);
        press("post_clr", 8'($urandom), 1'b0, 0);

        // Store and clear together: clear wins.
        press("both", 8'($urandom), 1'b0, 2);

        for (int i = 0; i < 10; i++) begin
            int r;
            r = int'($urandom_range(0, 5));
            if (r == 0) clear_only($sformatf("rnd%0d_clr", i));
            else press($sformatf("rnd%0d", i), 8'($urandom), 1'($urandom), (r == 1) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
